fft_stage_scheduler: RTL
========================

Name: fft_stage_scheduler

Overview:
- Sequences the in-place radix-2 DIT FFT over the sample RAM after the AXI bridge has loaded all samples.
- Per stage, issues butterfly read address pairs and twiddle indices to the butterfly datapath and its RAM read port.
- Returns the same address pairs as write-back addresses PIPE_LAT cycles later, and drains the pipeline between stages.
- Pulses o_CALC_END when the last stage's final write-back completes, which releases the bridge into its read-out phase.

Parameters:
- ADDR_WIDTH, 12, sample RAM address width; maximum transform size is 2^ADDR_WIDTH points.
- PIPE_LAT, 4, cycles from butterfly issue (read) to write-back of the same pair; legal range 1..15.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_DATA_LOADED  in  1  start pulse from the bridge; sampled only in IDLE.
- i_LOG2N  in  4  log2 of the transform size; captured at start.
- i_HOLD  in  1  stalls new issues while high (RAM port contention); in-flight write-backs continue.
- o_RD_EN  out  1  butterfly issue valid.
- o_RD_ADDR_A  out  ADDR_WIDTH  upper butterfly input address.
- o_RD_ADDR_B  out  ADDR_WIDTH  lower butterfly input address.
- o_TWIDDLE_IDX  out  ADDR_WIDTH-1  twiddle ROM index, W_N^idx.
- o_WR_EN  out  1  write-back valid.
- o_WR_ADDR_A  out  ADDR_WIDTH  write-back address A.
- o_WR_ADDR_B  out  ADDR_WIDTH  write-back address B.
- o_STAGE  out  4  current stage s.
- o_BUSY  out  1  high in every state except IDLE.
- o_CALC_END  out  1  one-cycle completion pulse.
- o_ERR  out  1  one-cycle pulse on an illegal i_LOG2N at start.

Behaviour:
- Reset (i_rst=1 at a clock edge), in any state and including mid-transform: state goes to IDLE; all counters and the delay line are cleared; every output is 0. Reset takes priority over all other inputs.
- States are IDLE, ISSUE, DRAIN and DONE.
- IDLE:
  - On i_DATA_LOADED=1 with 1 <= i_LOG2N <= ADDR_WIDTH: latch L = i_LOG2N, set s=0 and k=0, and go to ISSUE.
  - On i_DATA_LOADED=1 with i_LOG2N = 0 or i_LOG2N > ADDR_WIDTH: assert o_ERR for one cycle and stay in IDLE.
  - i_DATA_LOADED is ignored in every state other than IDLE.
- ISSUE, while i_HOLD=0:
  - Drive o_RD_EN=1 and compute, all combinationally from the registers s and k:
  - half = 2^s and j = k mod half.
  - A = ((k >> s) << (s+1)) + j, and B = A + half.
  - TWIDDLE_IDX = j << (L-1-s).
  - Then increment k.
  - When k = 2^(L-1) - 1 is issued, set k=0 and go to DRAIN.
- ISSUE, while i_HOLD=1: o_RD_EN=0 and k holds.
- Write-back delay line:
  - A PIPE_LAT-deep shift register carries {valid, A, B}.
  - o_WR_EN, o_WR_ADDR_A and o_WR_ADDR_B equal the issue values exactly PIPE_LAT cycles after the issue cycle.
  - Holes caused by i_HOLD propagate as o_WR_EN=0.
- DRAIN:
  - No issues.
  - Leave DRAIN when the delay line holds no valid entry and none is being written this cycle. The next stage's first issue is therefore the cycle after the final write-back.
  - If s < L-1: increment s and go to ISSUE.
  - Otherwise go to DONE.
- DONE: o_CALC_END=1 for one cycle, then go to IDLE.
- o_STAGE = s while o_BUSY=1; it returns to 0 in IDLE.
- Timing with no holds: each stage lasts 2^(L-1) + PIPE_LAT cycles; the whole transform lasts L*(2^(L-1) + PIPE_LAT) cycles, plus 1 cycle for DONE.
- All address arithmetic is unsigned and ADDR_WIDTH wide; no value ever exceeds 2^L - 1.
- L = 1: a single stage with one butterfly, (0,1), twiddle 0.
- i_HOLD asserted in DRAIN or DONE has no effect.

Test Plan:
- L=3, PIPE_LAT=4, no hold, start pulse in cycle -1:
  - Stage 0 issues (0,1),(2,3),(4,5),(6,7) with twiddle 0,0,0,0 in cycles 0..3.
  - Stage 1 issues (0,2),(1,3),(4,6),(5,7) with twiddle 0,2,0,2 in cycles 8..11.
  - Stage 2 issues (0,4),(1,5),(2,6),(3,7) with twiddle 0,1,2,3 in cycles 16..19.
  - Final o_WR_EN in cycle 23; o_CALC_END in cycle 24; o_BUSY=0 in cycle 25.
- Write-back alignment: for each issue in the case above, o_WR_EN=1 with matching A/B exactly 4 cycles later, and o_WR_EN=0 otherwise.
- L=3, i_HOLD=1 during cycles 1..2: stage 0 issues land in cycles 0,3,4,5; o_WR_EN is low in cycles 5..6; stage 1 begins in cycle 10; o_CALC_END occurs in cycle 26.
- Illegal size: i_LOG2N=0, then i_LOG2N=13, each with a start pulse -> o_ERR pulses once each; o_BUSY stays 0; no o_RD_EN.
- i_rst=1 in cycle 10 of the L=3 run -> from the next cycle all outputs are 0 and the state is IDLE; a new start afterwards replays the L=3 sequence from cycle 0.
- L=1, then L=12:
  - L=1 -> one issue (0,1), o_CALC_END 1+PIPE_LAT cycles after the issue.
  - L=12 -> 12 stages of 2048 issues; the last issue is (2047,4095) with twiddle 2047; o_CALC_END occurs at cycle 12*(2048+4) = 24624.
- A start pulse while busy is ignored (no restart, no error).

Source files
------------

// File: rtl/fft_stage_scheduler.sv
// Address and twiddle sequencer for an in-place radix-2 DIT FFT over the sample RAM.
// Issues butterfly read pairs stage by stage and replays them as write-backs PIPE_LAT cycles later.
module fft_stage_scheduler #(
   parameter int ADDR_WIDTH = 12,
   parameter int PIPE_LAT   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_DATA_LOADED,
   input  logic [3:0]            i_LOG2N,
   input  logic                  i_HOLD,
   output logic                  o_RD_EN,
   output logic [ADDR_WIDTH-1:0] o_RD_ADDR_A,
   output logic [ADDR_WIDTH-1:0] o_RD_ADDR_B,
   output logic [ADDR_WIDTH-2:0] o_TWIDDLE_IDX,
   output logic                  o_WR_EN,
   output logic [ADDR_WIDTH-1:0] o_WR_ADDR_A,
   output logic [ADDR_WIDTH-1:0] o_WR_ADDR_B,
   output logic [3:0]            o_STAGE,
   output logic                  o_BUSY,
   output logic                  o_CALC_END,
   output logic                  o_ERR
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [4:0] MAX_LOG2N = 5'(ADDR_WIDTH);
   // Every delay-line slot except the output one; the output slot is the write-back happening now.
   localparam logic [PIPE_LAT-1:0] EARLY_MASK = PIPE_LAT'((64'd1 << (PIPE_LAT - 1)) - 64'd1);

   state_t                state;
   logic [3:0]            log2n_q;
   logic [3:0]            stage_q;
   logic [ADDR_WIDTH-1:0] k_q;
   logic                  busy_q;
   logic                  calc_end_q;
   logic                  err_q;

   logic [PIPE_LAT-1:0]   dl_vld;
   logic [ADDR_WIDTH-1:0] dl_a [PIPE_LAT];
   logic [ADDR_WIDTH-1:0] dl_b [PIPE_LAT];

   logic [ADDR_WIDTH-1:0] half;
   logic [ADDR_WIDTH-1:0] j_idx;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [ADDR_WIDTH-2:0] twid;
   logic [ADDR_WIDTH-1:0] last_k;
   logic                  issue;
   logic                  pending;
   logic                  start_ok;

   always_comb begin
      half     = ADDR_WIDTH'(1) << stage_q;
      j_idx    = k_q & (half - ADDR_WIDTH'(1));
      addr_a   = ((k_q >> stage_q) << (stage_q + 4'd1)) + j_idx;
      addr_b   = addr_a + half;
      twid     = (ADDR_WIDTH-1)'(j_idx << (log2n_q - 4'd1 - stage_q));
      last_k   = (ADDR_WIDTH'(1) << (log2n_q - 4'd1)) - ADDR_WIDTH'(1);
      issue    = (state == ISSUE) && !i_HOLD;
      pending  = |(dl_vld & EARLY_MASK);
      start_ok = (i_LOG2N != 4'd0) && ({1'b0, i_LOG2N} <= MAX_LOG2N);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dl_vld <= '0;
         for (int unsigned i = 0; i < PIPE_LAT; i++) begin
            dl_a[i] <= '0;
            dl_b[i] <= '0;
         end
      end else begin
         dl_vld[0] <= issue;
         dl_a[0]   <= issue ? addr_a : '0;
         dl_b[0]   <= issue ? addr_b : '0;
         for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_a[i]   <= dl_a[i-1];
            dl_b[i]   <= dl_b[i-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         log2n_q    <= '0;
         stage_q    <= '0;
         k_q        <= '0;
         busy_q     <= 1'b0;
         calc_end_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         calc_end_q <= 1'b0;
         err_q      <= 1'b0;
         case (state)
            IDLE: begin
               if (i_DATA_LOADED) begin
                  if (start_ok) begin
                     log2n_q <= i_LOG2N;
                     stage_q <= '0;
                     k_q     <= '0;
                     busy_q  <= 1'b1;
                     state   <= ISSUE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (!i_HOLD) begin
                  if (k_q == last_k) begin
                     k_q   <= '0;
                     state <= DRAIN;
                  end else begin
                     k_q <= k_q + ADDR_WIDTH'(1);
                  end
               end
            end
            DRAIN: begin
               if (!pending) begin
                  if (stage_q == log2n_q - 4'd1) begin
                     calc_end_q <= 1'b1;
                     state      <= DONE;
                  end else begin
                     stage_q <= stage_q + 4'd1;
                     state   <= ISSUE;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               stage_q <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_RD_EN       = issue;
   assign o_RD_ADDR_A   = issue ? addr_a : '0;
   assign o_RD_ADDR_B   = issue ? addr_b : '0;
   assign o_TWIDDLE_IDX = issue ? twid : '0;
   assign o_WR_EN       = dl_vld[PIPE_LAT-1];
   assign o_WR_ADDR_A   = dl_a[PIPE_LAT-1];
   assign o_WR_ADDR_B   = dl_b[PIPE_LAT-1];
   assign o_STAGE       = stage_q;
   assign o_BUSY        = busy_q;
   assign o_CALC_END    = calc_end_q;
   assign o_ERR         = err_q;

endmodule
